// File: rtl/pcpi_cmd_initiator.sv
// Issues single custom-0 PCPI instructions from a simple command stream and
// hands the coprocessor result (or a timeout error) back as a held response.
module pcpi_cmd_initiator #(
  parameter int          TIMEOUT = 16,
  parameter logic [6:0]  OPCODE  = 7'b0001011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_funct3,
  input  logic [4:0]  cmd_addr,
  input  logic [15:0] cmd_value,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic        rsp_err,
  output logic [15:0] busy_cycles
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]    r_state;
  logic          r_armed;
  logic [31:0]   r_insn;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_wr;
  logic          r_rsp_err;
  logic [15:0]   r_busy;

  logic w_accept;
  logic w_tmax;

  // r_armed keeps cmd_ready low until the first edge after reset release
  assign cmd_ready   = r_armed && (r_state == S_IDLE);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_tmax      = (r_tcnt == TW'(TIMEOUT - 1));

  assign pcpi_valid  = (r_state == S_ISSUE);
  assign pcpi_insn   = r_insn;
  assign pcpi_rs1    = 32'd0;
  assign pcpi_rs2    = 32'd0;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_data    = r_rsp_data;
  assign rsp_wr      = r_rsp_wr;
  assign rsp_err     = r_rsp_err;
  assign busy_cycles = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_insn     <= 32'd0;
      r_tcnt     <= '0;
      r_rsp_data <= 32'd0;
      r_rsp_wr   <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_busy     <= 16'd0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_insn  <= {1'b0, cmd_value, cmd_funct3, cmd_addr, OPCODE};
            r_tcnt  <= '0;
            r_busy  <= 16'd0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_busy != 16'hFFFF) r_busy <= r_busy + 16'd1;
          // completion outranks both wait and an expiring timeout
          if (pcpi_ready) begin
            r_rsp_data <= pcpi_rd;
            r_rsp_wr   <= pcpi_wr;
            r_rsp_err  <= 1'b0;
            r_state    <= S_RESP;
          end else if (pcpi_wait) begin
            r_tcnt <= '0;
          end else if (w_tmax) begin
            r_rsp_data <= 32'd0;
            r_rsp_wr   <= 1'b0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
